// File: rtl/xres_reset_sequencer_pkg.sv
// Shared definitions for the external reset sequencer: state encoding,
// state-port width and counter sizing helper.
package xres_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_ASSERT  = 3'd0,
    ST_FILTER  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SOFT    = 3'd4
  } seq_state_t;

  // Counter width for a count range of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xres_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment
// (pad reset in, domain resets and status out, software reset handshake).
interface xres_reset_sequencer_if
  import xres_seq_pkg::*;
#(
  parameter int N_DOMAINS = 3
);

  logic                   xres_a;
  logic [N_DOMAINS-1:0]   dom_resetb;
  logic                   seq_busy;
  logic [SEQ_STATE_W-1:0] seq_state;
  logic                   soft_req;
  logic                   soft_ack;

  modport master (
    input  xres_a,
    input  soft_req,
    output dom_resetb,
    output seq_busy,
    output seq_state,
    output soft_ack
  );

  modport slave (
    output xres_a,
    output soft_req,
    input  dom_resetb,
    input  seq_busy,
    input  seq_state,
    input  soft_ack
  );

endinterface

// File: rtl/xres_sync.sv
// Two-flop synchronizer bringing the asynchronous pad reset into the clock
// domain; both stages clear to 0 under the synchronous reset.
module xres_sync (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make the two stages a true shift register;
  // blocking ones here would collapse them into a single flop.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xres_reset_sequencer.sv
// External reset sequencer: synchronizes and glitch-filters the pad reset,
// then releases N_DOMAINS domain resets in order, STAGE_DELAY cycles apart.
// Define XRES_SEQ_SOFT_RST_EN to build the software reset (SOFT) path.
module xres_reset_sequencer
  import xres_seq_pkg::*;
#(
  parameter int N_DOMAINS     = 3,
  parameter int FILTER_CYCLES = 8,
  parameter int STAGE_DELAY   = 16,
  parameter int SOFT_PULSE    = 4
) (
  input logic                    clock,
  input logic                    resetb,
  xres_reset_sequencer_if.master bus
);

  localparam int FCNT_W = cnt_w(FILTER_CYCLES);
  localparam int DCNT_W = cnt_w(STAGE_DELAY);
  localparam int IDX_W  = cnt_w(N_DOMAINS);

  localparam logic [FCNT_W-1:0] F_LAST = FCNT_W'(FILTER_CYCLES - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]  I_LAST = IDX_W'(N_DOMAINS - 1);

  logic                 xres_s;
  seq_state_t           state;
  logic [FCNT_W-1:0]    fcnt;
  logic [DCNT_W-1:0]    dcnt;
  logic [IDX_W-1:0]     idx;
  logic [N_DOMAINS-1:0] dom_q;
  logic                 busy_q;

`ifdef XRES_SEQ_SOFT_RST_EN
  localparam int PCNT_W = cnt_w(SOFT_PULSE);
  localparam logic [PCNT_W-1:0] P_LAST = PCNT_W'(SOFT_PULSE - 1);

  logic [PCNT_W-1:0] pcnt;
  logic              soft_run;   // current RELEASE pass was started by SOFT
  logic              soft_ack_q;
`endif

  xres_sync u_sync (
    .clock  (clock),
    .resetb (resetb),
    .d      (bus.xres_a),
    .q      (xres_s)
  );

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state  <= ST_ASSERT;
      dom_q  <= '0;
      busy_q <= 1'b1;
      fcnt   <= '0;
      dcnt   <= '0;
      idx    <= '0;
`ifdef XRES_SEQ_SOFT_RST_EN
      pcnt       <= '0;
      soft_run   <= 1'b0;
      soft_ack_q <= 1'b0;
`endif
    end else begin
`ifdef XRES_SEQ_SOFT_RST_EN
      soft_ack_q <= 1'b0;
`endif
      // Loss of the pad reset wins over every count and request in flight.
      if (state != ST_ASSERT && !xres_s) begin
        state  <= ST_ASSERT;
        dom_q  <= '0;
        busy_q <= 1'b1;
`ifdef XRES_SEQ_SOFT_RST_EN
        soft_run <= 1'b0;
`endif
      end else begin
        case (state)
          ST_ASSERT: begin
            dom_q  <= '0;
            busy_q <= 1'b1;
            if (xres_s) begin
              state <= ST_FILTER;
              fcnt  <= '0;
            end
          end

          ST_FILTER: begin
            if (fcnt == F_LAST) begin
              state <= ST_RELEASE;
              idx   <= '0;
              dcnt  <= '0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end

          ST_RELEASE: begin
            if (dcnt == D_LAST) begin
              dom_q[idx] <= 1'b1;
              idx        <= idx + 1'b1;
              dcnt       <= '0;
              if (idx == I_LAST) begin
                state  <= ST_RUN;
                busy_q <= 1'b0;
`ifdef XRES_SEQ_SOFT_RST_EN
                soft_ack_q <= soft_run;
                soft_run   <= 1'b0;
`endif
              end
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end

          ST_RUN: begin
            dom_q <= '1;
`ifdef XRES_SEQ_SOFT_RST_EN
            if (bus.soft_req) begin
              state    <= ST_SOFT;
              pcnt     <= '0;
              dom_q    <= N_DOMAINS'(1);   // domain 0 stays out of reset
              busy_q   <= 1'b1;
              soft_run <= 1'b1;
            end
`endif
          end

`ifdef XRES_SEQ_SOFT_RST_EN
          ST_SOFT: begin
            if (pcnt == P_LAST) begin
              state <= ST_RELEASE;
              idx   <= IDX_W'(1);
              dcnt  <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
`endif

          default: begin
            state  <= ST_ASSERT;
            dom_q  <= '0;
            busy_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.dom_resetb = dom_q;
  assign bus.seq_busy   = busy_q;
  assign bus.seq_state  = state;

`ifdef XRES_SEQ_SOFT_RST_EN
  assign bus.soft_ack = soft_ack_q;
`else
  logic unused_soft_req;
  assign unused_soft_req = bus.soft_req;
  assign bus.soft_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Self-checking bench for xres_reset_sequencer: directed scenarios plus a
// randomized run, all compared against a timing-formula reference model.
module tb_xres_reset_sequencer;
  import xres_seq_pkg::*;

  localparam int N = 3;
  localparam int F = 8;
  localparam int S = 16;
  localparam int P = 4;
  localparam int W = N + 5;

`ifdef XRES_SEQ_SOFT_RST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetb;
  always #5 clock = ~clock;

  xres_reset_sequencer_if #(.N_DOMAINS(N)) bus ();

  xres_reset_sequencer #(
    .N_DOMAINS     (N),
    .FILTER_CYCLES (F),
    .STAGE_DELAY   (S),
    .SOFT_PULSE    (P)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = held in reset, 1 = pad-release sequence
  // started at edge t0, 2 = software reset requested at edge t0. Outputs
  // follow from the release-time formulas relative to t0.
  int  now  = 0;
  int  t0   = 0;
  int  mode = 0;
  bit  sy1  = 1'b0;
  bit  sy2  = 1'b0;
  logic [N-1:0] exp_dom   = '0;
  logic         exp_busy  = 1'b1;
  logic [2:0]   exp_state = 3'd0;
  logic         exp_ack   = 1'b0;

  task automatic model_eval();
    int base;
    int run_at;
    exp_ack = 1'b0;
    exp_dom = '0;
    if (mode == 0) begin
      exp_state = 3'd0;
    end else if (mode == 1) begin
      base   = t0 + F;
      run_at = base + N * S;
      for (int k = 0; k < N; k++) exp_dom[k] = (now >= base + (k + 1) * S);
      exp_state = (now < base) ? 3'd1 : (now < run_at) ? 3'd2 : 3'd3;
    end else begin
      base   = t0 + P;
      run_at = base + (N - 1) * S;
      exp_dom[0] = 1'b1;
      for (int k = 1; k < N; k++) exp_dom[k] = (now >= base + k * S);
      exp_state = (now < base) ? 3'd4 : (now < run_at) ? 3'd2 : 3'd3;
      exp_ack   = (now == run_at);
    end
    exp_busy = (exp_state != 3'd3);
  endtask

  task automatic model_edge(input logic rb, input logic xa, input logic sr);
    bit xs;
    bit was_run;
    now++;
    was_run = (exp_state == 3'd3);
    if (!rb) begin
      mode = 0;
      sy1  = 1'b0;
      sy2  = 1'b0;
    end else begin
      xs  = sy2;
      sy2 = sy1;
      sy1 = xa;
      if (mode == 0) begin
        if (xs) begin
          mode = 1;
          t0   = now;
        end
      end else if (!xs) begin
        mode = 0;
      end else if (was_run && sr && SOFT_EN) begin
        mode = 2;
        t0   = now;
      end
    end
    model_eval();
  endtask

  task automatic step(input logic rb, input logic xa, input logic sr);
    @(negedge clock);
    resetb     = rb;
    bus.xres_a = xa;
    bus.soft_req = sr;
    @(posedge clock);
    model_edge(rb, xa, sr);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    if (bus.dom_resetb !== 3'b000) begin
      n_fail++; $display("FAIL reset_dom got=%b want=000", bus.dom_resetb);
    end
    n_tests++;
    if (bus.seq_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy got=%b want=1", bus.seq_busy);
    end
    n_tests++;
    if (bus.seq_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d want=0", bus.seq_state);
    end
    n_tests++;
    if (bus.soft_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack got=%b want=0", bus.soft_ack);
    end
    n_tests++;
  endtask

  task automatic test_release();
    logic [W-1:0] got;
    logic [W-1:0] want;
    for (int e = 1; e <= 62; e++) begin
      step(1'b1, 1'b1, 1'b0);
      got  = {bus.dom_resetb, bus.seq_busy, bus.seq_state, bus.soft_ack};
      want = {exp_dom, exp_busy, exp_state, exp_ack};
      if (got !== want) begin
        n_fail++; $display("FAIL release_edge%0d got=%b want=%b", e, got, want);
      end
      n_tests++;
      if (e == 26 || e == 27 || e == 43 || e == 59) begin
        want[N-1:0] = (e == 26) ? 3'b000 : (e == 27) ? 3'b001 : (e == 43) ? 3'b011 : 3'b111;
        if (bus.dom_resetb !== want[N-1:0]) begin
          n_fail++; $display("FAIL release_dom_at%0d got=%b want=%b", e, bus.dom_resetb, want[N-1:0]);
        end
        n_tests++;
      end
      if (e == 58 || e == 59) begin
        if (bus.seq_busy !== (e == 58)) begin
          n_fail++; $display("FAIL release_busy_at%0d got=%b", e, bus.seq_busy);
        end
        n_tests++;
      end
    end
    if (bus.seq_state !== 3'd3) begin
      n_fail++; $display("FAIL release_run got=%0d want=3", bus.seq_state);
    end
    n_tests++;
  endtask

  task automatic test_glitch();
    bit saw_filter = 1'b0;
    bit saw_release = 1'b0;
    bit dom_ok = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 15; e++) begin
      step(1'b1, (e <= 5), 1'b0);
      if (bus.seq_state == 3'd1) saw_filter = 1'b1;
      if (bus.seq_state == 3'd2) saw_release = 1'b1;
      if (bus.dom_resetb != '0) dom_ok = 1'b0;
    end
    if (saw_filter !== 1'b1 || saw_release !== 1'b0 || dom_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch got filter=%b release=%b dom_ok=%b want 1 0 1", saw_filter, saw_release, dom_ok);
    end
    n_tests++;
    if (bus.seq_state !== 3'd0) begin
      n_fail++; $display("FAIL glitch_final got=%0d want=0", bus.seq_state);
    end
    n_tests++;
  endtask

  task automatic test_drop_after_release();
    logic [W-1:0] got;
    logic [W-1:0] want;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 30; e++) step(1'b1, 1'b1, 1'b0);
    for (int d = 1; d <= 5; d++) begin
      step(1'b1, 1'b0, 1'b0);
      if (d == 2 || d == 3) begin
        got  = {bus.dom_resetb, bus.seq_state};
        want = (d == 2) ? {3'b001, 3'd2} : {3'b000, 3'd0};
        if (got[N+2:0] !== want[N+2:0]) begin
          n_fail++; $display("FAIL drop_edge%0d got=%b want=%b", d, got[N+2:0], want[N+2:0]);
        end
        n_tests++;
      end
    end
    for (int k = 1; k <= 62; k++) begin
      step(1'b1, 1'b1, 1'b0);
      got  = {bus.dom_resetb, bus.seq_busy, bus.seq_state, bus.soft_ack};
      want = {exp_dom, exp_busy, exp_state, exp_ack};
      if (got !== want) begin
        n_fail++; $display("FAIL restart_edge%0d got=%b want=%b", k, got, want);
      end
      n_tests++;
      if (k == 26 || k == 27) begin
        if (bus.dom_resetb !== ((k == 27) ? 3'b001 : 3'b000)) begin
          n_fail++; $display("FAIL restart_dom_at%0d got=%b", k, bus.dom_resetb);
        end
        n_tests++;
      end
    end
  endtask

  task automatic test_soft();
    logic [W-1:0] got;
    logic [W-1:0] want;
    for (int k = 0; k <= 40; k++) begin
      step(1'b1, 1'b1, (k == 0));
      got  = {bus.dom_resetb, bus.seq_busy, bus.seq_state, bus.soft_ack};
      want = {exp_dom, exp_busy, exp_state, exp_ack};
      if (got !== want) begin
        n_fail++; $display("FAIL soft_edge%0d got=%b want=%b", k, got, want);
      end
      n_tests++;
`ifdef XRES_SEQ_SOFT_RST_EN
      if (k == 0 || k == 19 || k == 20 || k == 36 || k == 37) begin
        want = (k == 0)  ? {3'b001, 1'b1, 3'd4, 1'b0} :
               (k == 19) ? {3'b001, 1'b1, 3'd2, 1'b0} :
               (k == 20) ? {3'b011, 1'b1, 3'd2, 1'b0} :
               (k == 36) ? {3'b111, 1'b0, 3'd3, 1'b1} :
                           {3'b111, 1'b0, 3'd3, 1'b0};
        if (got !== want) begin
          n_fail++; $display("FAIL soft_at%0d got=%b want=%b", k, got, want);
        end
        n_tests++;
      end
`else
      if (got !== {3'b111, 1'b0, 3'd3, 1'b0}) begin
        n_fail++; $display("FAIL soft_ignored_edge%0d got=%b want=11103_0", k, got);
      end
      n_tests++;
`endif
    end
  endtask

  task automatic test_soft_vs_xres();
    logic [W-1:0] got;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1);
      got = {bus.dom_resetb, bus.seq_busy, bus.seq_state, bus.soft_ack};
      if (got !== {3'b000, 1'b1, 3'd0, 1'b0}) begin
        n_fail++; $display("FAIL soft_vs_xres_edge%0d got=%b want=00010000", k, got);
      end
      n_tests++;
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midway();
    logic [W-1:0] got;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
      for (int e = 1; e <= ((pass == 0) ? 30 : 62); e++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      got = {bus.dom_resetb, bus.seq_busy, bus.seq_state, bus.soft_ack};
      if (got !== {3'b000, 1'b1, 3'd0, 1'b0}) begin
        n_fail++; $display("FAIL reset_midway_pass%0d got=%b want=00010000", pass, got);
      end
      n_tests++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] got;
    logic [W-1:0] want;
    logic xa = 1'b1;
    logic sr = 1'b0;
    logic rb;
    int   run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        xa       = ~xa;
        run_left = xa ? $urandom_range(1, 140) : $urandom_range(1, 8);
      end
      run_left--;
      if ($urandom_range(0, 11) == 0) sr = ~sr;
      rb = ($urandom_range(0, 599) != 0);
      step(rb, xa, sr);
      got  = {bus.dom_resetb, bus.seq_busy, bus.seq_state, bus.soft_ack};
      want = {exp_dom, exp_busy, exp_state, exp_ack};
      if (got !== want) begin
        n_fail++; $display("FAIL random_cycle%0d got=%b want=%b", c, got, want);
      end
      n_tests++;
    end
  endtask

  initial begin
    resetb       = 1'b0;
    bus.xres_a   = 1'b0;
    bus.soft_req = 1'b0;
    model_eval();
    test_reset();
    test_release();
    test_soft();
    test_soft_vs_xres();
    test_glitch();
    test_drop_after_release();
    test_reset_midway();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
